sram_bridge: RTL and testbench

SRAM_BRIDGE -- requirements
Module: sram_bridge

---
 rtl/sram_bridge_pkg.sv | 15 +
 rtl/sram_wait_counter.sv | 27 ++
 rtl/sram_bridge.sv | 121 ++++++++++++
 tb/tb_sram_bridge.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared types and defaults for the asynchronous SRAM bridge.
package sram_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StAck,
    StRecover
  } state_e;

  localparam int unsigned WaitCyclesDefault = 4;
  localparam logic [7:0]  BankDefault       = 8'h00;
  localparam int unsigned CntW              = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Access-length down-counter: load on accept, count down while an access runs.
module sram_wait_counter
  import sram_bridge_pkg::*;
(
  input  logic            clk_i,
  input  logic            res_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_bridge.sv
// CPU bus to asynchronous SRAM bridge: latch request, fixed-length access, ack, recovery clock.
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WaitCyclesDefault,
  parameter logic [7:0]  BANK        = BankDefault
) (
  input  logic        clk_i,
  input  logic        res_i,
  input  logic [14:0] adr_i,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic [1:0]  stb_i,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  output logic        ack_o,
  output logic [22:0] sram_adr_o,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe_o,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic        sram_lb_n_o,
  output logic        sram_ub_n_o
);

  state_e      state_q, state_d;
  logic [14:0] adr_q;
  logic        we_q;
  logic [1:0]  stb_q;
  logic [15:0] wdat_q;
  logic [15:0] dat_q;
  logic        req;
  logic        accept;
  logic        capture;
  logic        cnt_zero;

  assign req     = cyc_i & (|stb_i);
  assign accept  = (state_q == StIdle) & req;
  assign capture = (state_q == StAccess) & cyc_i & cnt_zero & ~we_q;

  sram_wait_counter u_wait_counter (
    .clk_i      (clk_i),
    .res_i      (res_i),
    .load_i     (accept),
    .load_val_i (CntW'(WAIT_CYCLES - 1)),
    .dec_i      (state_q == StAccess),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      state_q <= StIdle;
      adr_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= '0;
      wdat_q  <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        adr_q  <= adr_i;
        we_q   <= we_i;
        stb_q  <= stb_i;
        wdat_q <= dat_i;
      end
      if (capture) begin
        dat_q <= sram_dq_i;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sram_ce_n_o  = 1'b1;
    sram_oe_n_o  = 1'b1;
    sram_we_n_o  = 1'b1;
    sram_lb_n_o  = 1'b1;
    sram_ub_n_o  = 1'b1;
    sram_dq_oe_o = 1'b0;
    ack_o        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) state_d = StAccess;
      end
      StAccess: begin
        sram_ce_n_o = 1'b0;
        sram_lb_n_o = ~stb_q[0];
        sram_ub_n_o = ~stb_q[1];
        if (we_q) begin
          // WE rises on the last access clock so data is held past the rising edge.
          sram_dq_oe_o = 1'b1;
          sram_we_n_o  = cnt_zero;
        end else begin
          sram_oe_n_o = 1'b0;
        end
        if (!cyc_i) begin
          state_d = StRecover;
        end else if (cnt_zero) begin
          state_d = StAck;
        end
      end
      StAck: begin
        ack_o   = 1'b1;
        state_d = StRecover;
      end
      StRecover: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign dat_o      = dat_q;
  assign sram_dq_o  = wdat_q;
  assign sram_adr_o = {BANK, adr_q};

endmodule

// File: tb/tb_sram_bridge.sv
// Self-checking bench: transaction-timeline model checked every cycle, plus directed scenarios.
module tb_sram_bridge;

  localparam int unsigned W  = 4;
  localparam logic [7:0]  BK = 8'h00;

  logic        clk_i;
  logic        res_i;
  logic [14:0] adr_i;
  logic        we_i;
  logic        cyc_i;
  logic [1:0]  stb_i;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        ack_o;
  logic [22:0] sram_adr_o;
  logic [15:0] sram_dq_i;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe_o;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
  logic        sram_lb_n_o;
  logic        sram_ub_n_o;

  sram_bridge #(
    .WAIT_CYCLES (W),
    .BANK        (BK)
  ) dut (
    .clk_i        (clk_i),
    .res_i        (res_i),
    .adr_i        (adr_i),
    .we_i         (we_i),
    .cyc_i        (cyc_i),
    .stb_i        (stb_i),
    .dat_i        (dat_i),
    .dat_o        (dat_o),
    .ack_o        (ack_o),
    .sram_adr_o   (sram_adr_o),
    .sram_dq_i    (sram_dq_i),
    .sram_dq_o    (sram_dq_o),
    .sram_dq_oe_o (sram_dq_oe_o),
    .sram_ce_n_o  (sram_ce_n_o),
    .sram_oe_n_o  (sram_oe_n_o),
    .sram_we_n_o  (sram_we_n_o),
    .sram_lb_n_o  (sram_lb_n_o),
    .sram_ub_n_o  (sram_ub_n_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  bit model_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Model: a transaction accepted at cycle t0 occupies cycles t0+1..t0+W (access),
  // t0+W+1 (ack) and t0+W+2 (recovery); m_k is the current cycle's offset from t0.
  bit          m_busy = 1'b0;
  int          m_k = 0;
  logic [14:0] m_adr = '0;
  logic        m_we = 1'b0;
  logic [1:0]  m_stb = '0;
  logic [15:0] m_dat = '0;
  logic [15:0] m_rd = '0;

  always @(negedge clk_i) begin : cmp_blk
    logic e_ce, e_oe, e_we, e_lb, e_ub, e_dqoe, e_ack;
    bit   in_acc;
    if (model_on) begin
      if (!res_i) begin
        m_busy = 1'b0;
        m_k    = 0;
        m_adr  = '0;
        m_rd   = '0;
      end
      e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_lb = 1'b1; e_ub = 1'b1;
      e_dqoe = 1'b0; e_ack = 1'b0;
      in_acc = m_busy && (m_k >= 1) && (m_k <= W);
      if (in_acc) begin
        e_ce = 1'b0;
        e_lb = ~m_stb[0];
        e_ub = ~m_stb[1];
        if (m_we) begin
          e_dqoe = 1'b1;
          e_we   = (m_k == W);
        end else begin
          e_oe = 1'b0;
        end
      end
      if (m_busy && (m_k == W + 1)) e_ack = 1'b1;
      chk("ce_n", sram_ce_n_o, e_ce);
      chk("oe_n", sram_oe_n_o, e_oe);
      chk("we_n", sram_we_n_o, e_we);
      chk("lb_n", sram_lb_n_o, e_lb);
      chk("ub_n", sram_ub_n_o, e_ub);
      chk("dq_oe", sram_dq_oe_o, e_dqoe);
      chk("ack", ack_o, e_ack);
      chk("sram_adr", sram_adr_o, {BK, m_adr});
      chk("dat_o", dat_o, m_rd);
      chk("oe_dq_overlap", sram_dq_oe_o & ~sram_oe_n_o, 1'b0);
      if (e_dqoe) chk("dq_o", sram_dq_o, m_dat);
      if (res_i) begin
        if (!m_busy) begin
          if (cyc_i && (stb_i != 2'b00)) begin
            m_busy = 1'b1;
            m_k    = 1;
            m_adr  = adr_i;
            m_we   = we_i;
            m_stb  = stb_i;
            m_dat  = dat_i;
          end
        end else if (m_k <= W) begin
          if (!cyc_i) begin
            m_k = W + 2;
          end else begin
            if ((m_k == W) && !m_we) m_rd = sram_dq_i;
            m_k++;
          end
        end else if (m_k == W + 1) begin
          m_k++;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  end

  logic        rec_ack [40];
  logic        rec_ce  [40];
  logic        rec_oe  [40];
  logic        rec_we  [40];
  logic        rec_dqoe[40];
  logic        rec_lb  [40];
  logic        rec_ub  [40];
  logic [22:0] rec_adr [40];
  logic [15:0] rec_dqo [40];

  // Cycle 0 is the cycle whose closing edge samples the request already on the inputs.
  task automatic record(input int n, input bit one_shot, input int drop_at);
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      rec_ack[c]  = ack_o;
      rec_ce[c]   = sram_ce_n_o;
      rec_oe[c]   = sram_oe_n_o;
      rec_we[c]   = sram_we_n_o;
      rec_dqoe[c] = sram_dq_oe_o;
      rec_lb[c]   = sram_lb_n_o;
      rec_ub[c]   = sram_ub_n_o;
      rec_adr[c]  = sram_adr_o;
      rec_dqo[c]  = sram_dq_o;
      step();
      if (one_shot && (c == 0)) begin
        stb_i = 2'b00;
        adr_i = 15'($urandom);
        dat_i = 16'($urandom);
      end
      if (c == drop_at) cyc_i = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, ack1, ack2, n_oe, n_we, n_dq, n_ce, bad;
    res_i = 1'b1; cyc_i = 1'b0; stb_i = '0; we_i = 1'b0;
    adr_i = '0; dat_i = '0; sram_dq_i = '0;
    #3 res_i = 1'b0;
    repeat (3) step();
    model_on = 1'b1;
    @(negedge clk_i);
    chk("reset_dat_o", dat_o, 16'h0000);
    chk("reset_adr", sram_adr_o, 23'h000000);
    chk("reset_ce_n", sram_ce_n_o, 1'b1);
    step();
    res_i = 1'b1;
    step();

    // Single read
    adr_i = 15'h1234; we_i = 1'b0; stb_i = 2'b11; cyc_i = 1'b1; sram_dq_i = 16'hBEEF;
    record(10, 1'b1, -1);
    cyc_i = 1'b0;
    acks = 0; ack1 = -1; n_oe = 0;
    for (int c = 0; c < 10; c++) begin
      if (rec_ack[c]) begin if (acks == 0) ack1 = c; acks++; end
      if (!rec_oe[c]) n_oe++;
    end
    chk("rd_oe_low_cycles", n_oe, 4);
    chk("rd_ack_cycle", ack1, 5);
    chk("rd_ack_count", acks, 1);
    chk("rd_sram_adr", rec_adr[1], 23'h001234);
    chk("rd_dat_o", dat_o, 16'hBEEF);

    // Single low-byte write
    step();
    adr_i = 15'h0042; we_i = 1'b1; stb_i = 2'b01; dat_i = 16'hA55A; cyc_i = 1'b1;
    record(10, 1'b1, -1);
    cyc_i = 1'b0;
    acks = 0; n_we = 0; n_dq = 0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (rec_ack[c]) acks++;
      if (!rec_we[c]) n_we++;
      if (rec_dqoe[c]) begin
        n_dq++;
        if (rec_dqo[c] != 16'hA55A) bad++;
      end
    end
    chk("wr_we_low_cycles", n_we, 3);
    chk("wr_dq_oe_cycles", n_dq, 4);
    chk("wr_dq_o_value_errs", bad, 0);
    chk("wr_lb_n", rec_lb[1], 1'b0);
    chk("wr_ub_n", rec_ub[1], 1'b1);
    chk("wr_ack_count", acks, 1);
    chk("wr_dat_o_kept", dat_o, 16'hBEEF);

    // Back-to-back reads
    step();
    adr_i = 15'h0100; we_i = 1'b0; stb_i = 2'b11; cyc_i = 1'b1; sram_dq_i = 16'h1357;
    record(20, 1'b0, -1);
    stb_i = 2'b00;
    acks = 0; ack1 = -1; ack2 = -1;
    for (int c = 0; c < 20; c++) begin
      if (rec_ack[c]) begin
        if (acks == 0) ack1 = c;
        else if (acks == 1) ack2 = c;
        acks++;
      end
    end
    chk("b2b_first_ack", ack1, 5);
    chk("b2b_ack_spacing", ack2 - ack1, 7);
    repeat (4) step();
    cyc_i = 1'b0;
    step();

    // Abort: cyc_i dropped for the second access clock
    adr_i = 15'h0777; we_i = 1'b0; stb_i = 2'b11; cyc_i = 1'b1; sram_dq_i = 16'hDEAD;
    record(4, 1'b1, 1);
    acks = 0;
    for (int c = 0; c < 4; c++) if (rec_ack[c]) acks++;
    chk("abort_no_ack", acks, 0);
    chk("abort_ce_in_access", rec_ce[2], 1'b0);
    chk("abort_ce_after", rec_ce[3], 1'b1);
    chk("abort_oe_after", rec_oe[3], 1'b1);
    chk("abort_dat_o_kept", dat_o, 16'h1357);
    cyc_i = 1'b1; stb_i = 2'b10;
    record(3, 1'b1, -1);
    chk("abort_then_accept", rec_ce[1], 1'b0);
    repeat (6) step();
    cyc_i = 1'b0;
    step();

    // cyc_i with no strobes is ignored
    cyc_i = 1'b1; stb_i = 2'b00;
    record(10, 1'b0, -1);
    acks = 0; n_ce = 0;
    for (int c = 0; c < 10; c++) begin
      if (rec_ack[c]) acks++;
      if (!rec_ce[c]) n_ce++;
    end
    chk("nostb_ce_low", n_ce, 0);
    chk("nostb_ack", acks, 0);

    // Reset mid-access, then request right after release
    adr_i = 15'h0555; we_i = 1'b0; stb_i = 2'b11; sram_dq_i = 16'h2468;
    record(2, 1'b1, -1);
    res_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ce_n", sram_ce_n_o, 1'b1);
    chk("rst_oe_n", sram_oe_n_o, 1'b1);
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_dat_o", dat_o, 16'h0000);
    step();
    res_i = 1'b1; stb_i = 2'b11;
    record(3, 1'b1, -1);
    chk("rst_first_accept", rec_ce[1], 1'b0);
    repeat (8) step();
    cyc_i = 1'b0;
    step();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      cyc_i     = ($urandom_range(0, 9) != 0);
      stb_i     = 2'($urandom);
      we_i      = 1'($urandom);
      adr_i     = 15'($urandom);
      dat_i     = 16'($urandom);
      sram_dq_i = 16'($urandom);
      res_i     = ($urandom_range(0, 299) != 0);
      step();
    end
    res_i = 1'b1; cyc_i = 1'b0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
